// File: rtl/palette_pkg.sv
// Shared types and constants for the palette colour encoder.
// Provides rgb_t, enc_state_t, sizing constants and a channel |a-b| helper.
package palette_pkg;

   localparam int PAL_ENTRIES = 16;
   localparam int PAL_IDX_W   = 4;
   localparam int PAL_CH_W    = 4;
   localparam int DIST_W      = PAL_CH_W + 2;

   typedef struct packed {
      logic [PAL_CH_W-1:0] red;
      logic [PAL_CH_W-1:0] green;
      logic [PAL_CH_W-1:0] blue;
   } rgb_t;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      HOLD
   } enc_state_t;

   function automatic logic [DIST_W-1:0] abs_diff(
      input logic [PAL_CH_W-1:0] a,
      input logic [PAL_CH_W-1:0] b
   );
      if (a > b) return DIST_W'(a - b);
      else       return DIST_W'(b - a);
   endfunction

endpackage

// File: rtl/palette_color_encoder_color_distance.sv
// Combinational Manhattan distance between two 12-bit RGB colours.
// Ports: i_a, i_b (rgb_t) in; o_dist (DIST_W) out, max 45.
module color_distance
   import palette_pkg::*;
(
   input  rgb_t              i_a,
   input  rgb_t              i_b,
   output logic [DIST_W-1:0] o_dist
);

   always_comb begin
      o_dist = abs_diff(i_a.red,   i_b.red)
             + abs_diff(i_a.green, i_b.green)
             + abs_diff(i_a.blue,  i_b.blue);
   end

endmodule

// File: rtl/palette_color_encoder.sv
// Maps RGB pixels to the closest entry of a 16-entry writable palette.
// Ports: Clk/Reset_n; pal_we/waddr/wdata/wready palette write port;
// in_valid/in_ready/in_red/green/blue pixel in; out_valid/out_ready/
// out_index/out_exact result out. Optional: PALETTE_ENC_EARLY_EXIT_EN
// ends the scan on the first exact match.
module palette_color_encoder
   import palette_pkg::*;
#(
   parameter int NUM_ENTRIES = PAL_ENTRIES,
   parameter int IDX_W       = PAL_IDX_W,
   parameter int CH_W        = PAL_CH_W
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              pal_we,
   input  logic [IDX_W-1:0]  pal_waddr,
   input  logic [3*CH_W-1:0] pal_wdata,
   output logic              pal_wready,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CH_W-1:0]   in_red,
   input  logic [CH_W-1:0]   in_green,
   input  logic [CH_W-1:0]   in_blue,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_index,
   output logic              out_exact
);

   enc_state_t        r_state;
   enc_state_t        w_state_nxt;
   rgb_t              r_pal [NUM_ENTRIES];
   rgb_t              r_pix;
   logic [IDX_W-1:0]  r_cnt;
   logic [DIST_W-1:0] r_best_d;
   logic [IDX_W-1:0]  r_best_idx;

   logic [DIST_W-1:0] w_dist;
   logic              w_accept;
   logic              w_better;
   logic              w_last;

   color_distance u_dist (
      .i_a    (r_pix),
      .i_b    (r_pal[r_cnt]),
      .o_dist (w_dist)
   );

   assign w_last = (r_cnt == IDX_W'(NUM_ENTRIES - 1));

   always_comb begin
      w_state_nxt = r_state;
      pal_wready  = 1'b0;
      in_ready    = 1'b0;
      w_accept    = 1'b0;
      w_better    = 1'b0;
      unique case (r_state)
         IDLE: begin
            pal_wready = 1'b1;
            // A pending write takes priority over the pixel.
            in_ready   = ~pal_we;
            w_accept   = in_valid & ~pal_we;
            if (w_accept) w_state_nxt = SCAN;
         end
         SCAN: begin
            // Strict compare keeps the lowest index on ties.
            w_better = (w_dist < r_best_d);
            if (w_last) w_state_nxt = HOLD;
`ifdef PALETTE_ENC_EARLY_EXIT_EN
            if (w_dist == '0) w_state_nxt = HOLD;
`endif
         end
         HOLD: begin
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign out_valid = (r_state == HOLD);
   assign out_index = out_valid ? r_best_idx : '0;
   assign out_exact = out_valid & (r_best_d == '0);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state    <= IDLE;
         r_pix      <= '0;
         r_cnt      <= '0;
         r_best_d   <= '0;
         r_best_idx <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) r_pal[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (pal_we && pal_wready) r_pal[pal_waddr] <= pal_wdata;
         if (w_accept) begin
            r_pix      <= {in_red, in_green, in_blue};
            r_cnt      <= '0;
            r_best_d   <= '1;
            r_best_idx <= '0;
         end
         if (r_state == SCAN) begin
            if (w_better) begin
               r_best_d   <= w_dist;
               r_best_idx <= r_cnt;
            end
            if (!w_last) r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_palette_color_encoder.sv
// Self-checking bench for palette_color_encoder: directed cases plus
// randomized traffic compared each cycle against a behavioural model.
module tb_palette_color_encoder;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        pal_we = 1'b0;
   logic [3:0]  pal_waddr = '0;
   logic [11:0] pal_wdata = '0;
   logic        pal_wready;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_red = '0;
   logic [3:0]  in_green = '0;
   logic [3:0]  in_blue = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [3:0]  out_index;
   logic        out_exact;

`ifdef PALETTE_ENC_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
   localparam int LAT_6DF = 4;
   localparam int LAT_000 = 2;
`else
   localparam bit EARLY = 1'b0;
   localparam int LAT_6DF = 17;
   localparam int LAT_000 = 17;
`endif

   palette_color_encoder dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .pal_we     (pal_we),
      .pal_waddr  (pal_waddr),
      .pal_wdata  (pal_wdata),
      .pal_wready (pal_wready),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_red     (in_red),
      .in_green   (in_green),
      .in_blue    (in_blue),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_index  (out_index),
      .out_exact  (out_exact)
   );

   always #5 Clk = ~Clk;

   int total = 0;
   int bad = 0;

   // Behavioural model: mode 0 idle, 1 busy, 2 result held.
   logic [11:0] m_pal [16];
   int m_mode, m_wait, m_idx, m_exact;

   function automatic int cdist(input logic [11:0] a, input logic [11:0] b);
      int d = 0;
      for (int c = 0; c < 3; c++) begin
         int x = int'(a[c*4 +: 4]);
         int y = int'(b[c*4 +: 4]);
         d += (x > y) ? x - y : y - x;
      end
      return d;
   endfunction

   function automatic void best_of(input logic [11:0] p,
      output int idx, output int exact, output int len);
      int bd = 1000;
      idx = 0;
      for (int i = 0; i < 16; i++) begin
         int d = cdist(p, m_pal[i]);
         if (d < bd) begin
            bd = d;
            idx = i;
         end
      end
      exact = (bd == 0) ? 1 : 0;
      len = (EARLY && bd == 0) ? idx + 1 : 16;
   endfunction

   always @(posedge Clk or negedge Reset_n) begin
      int li, le, ll;
      if (!Reset_n) begin
         m_mode <= 0;
         m_wait <= 0;
         m_idx <= 0;
         m_exact <= 0;
         for (int i = 0; i < 16; i++) m_pal[i] <= '0;
      end else begin
         case (m_mode)
            0: begin
               if (pal_we) m_pal[pal_waddr] <= pal_wdata;
               else if (in_valid) begin
                  best_of({in_red, in_green, in_blue}, li, le, ll);
                  m_idx <= li;
                  m_exact <= le;
                  m_wait <= ll;
                  m_mode <= 1;
               end
            end
            1: begin
               m_wait <= m_wait - 1;
               if (m_wait == 1) m_mode <= 2;
            end
            default: if (out_ready) m_mode <= 0;
         endcase
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: timed out waiting at %0t", name, $time);
   endtask

   task automatic wr(input logic [3:0] a, input logic [11:0] d);
      int n = 0;
      @(posedge Clk); #1;
      pal_we = 1'b1;
      pal_waddr = a;
      pal_wdata = d;
      @(negedge Clk);
      while (!pal_wready && n < 200) begin
         @(negedge Clk);
         n++;
      end
      if (!pal_wready) timeout("wr_accept");
      @(posedge Clk); #1;
      pal_we = 1'b0;
   endtask

   task automatic hs_wait(output int lat);
      int n = 0;
      @(negedge Clk);
      while (!in_ready && n < 200) begin
         @(negedge Clk);
         n++;
      end
      if (!in_ready) timeout("in_accept");
      @(posedge Clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(negedge Clk);
         lat++;
      end
      if (!out_valid) timeout("out_valid");
   endtask

   task automatic send(input logic [11:0] p, output int lat);
      @(posedge Clk); #1;
      in_valid = 1'b1;
      {in_red, in_green, in_blue} = p;
      hs_wait(lat);
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while (out_valid && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (out_valid) timeout("drain");
   endtask

   initial begin
      int lat;
      int n;
      int op;
      logic [11:0] p;

      fork
         forever begin
            @(negedge Clk);
            if (Reset_n) begin
               chk("out_valid", int'(out_valid), (m_mode == 2) ? 1 : 0);
               chk("out_index", int'(out_index), (m_mode == 2) ? m_idx : 0);
               chk("out_exact", int'(out_exact), (m_mode == 2) ? m_exact : 0);
               chk("in_ready", int'(in_ready), (m_mode == 0 && !pal_we) ? 1 : 0);
               chk("pal_wready", int'(pal_wready), (m_mode == 0) ? 1 : 0);
            end
         end
      join_none

      repeat (3) @(posedge Clk);
      #1 Reset_n = 1'b1;
      @(negedge Clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_index", int'(out_index), 0);
      chk("rst_out_exact", int'(out_exact), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_pal_wready", int'(pal_wready), 1);

      for (int i = 0; i < 16; i++)
         wr(4'(i), (i == 2) ? 12'h6DF : (i == 8) ? 12'h000 : 12'hFFF);

      send(12'h6DF, lat);
      chk("p6DF_index", int'(out_index), 2);
      chk("p6DF_exact", int'(out_exact), 1);
      chk("p6DF_latency", lat, LAT_6DF);
      drain();

      send(12'hFFF, lat);
      chk("pFFF_index", int'(out_index), 0);
      chk("pFFF_exact", int'(out_exact), 1);
      drain();

      send(12'h5CE, lat);
      chk("p5CE_index", int'(out_index), 2);
      chk("p5CE_exact", int'(out_exact), 0);
      drain();

      send(12'h111, lat);
      chk("p111_index", int'(out_index), 8);
      chk("p111_exact", int'(out_exact), 0);
      drain();

      out_ready = 1'b0;
      send(12'h6DF, lat);
      pal_we = 1'b1;
      pal_waddr = 4'd5;
      pal_wdata = 12'h123;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_index", int'(out_index), 2);
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_wready", int'(pal_wready), 0);
      end
      out_ready = 1'b1;
      n = 0;
      @(negedge Clk);
      while (!pal_wready && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (!pal_wready) timeout("bp_write");
      @(posedge Clk); #1;
      pal_we = 1'b0;
      send(12'h123, lat);
      chk("p123_index", int'(out_index), 5);
      chk("p123_exact", int'(out_exact), 1);
      drain();

      @(posedge Clk); #1;
      pal_we = 1'b1;
      pal_waddr = 4'd3;
      pal_wdata = 12'h5CE;
      in_valid = 1'b1;
      {in_red, in_green, in_blue} = 12'h5CE;
      @(negedge Clk);
      chk("both_in_ready", int'(in_ready), 0);
      @(posedge Clk); #1;
      pal_we = 1'b0;
      hs_wait(lat);
      chk("both_index", int'(out_index), 3);
      chk("both_exact", int'(out_exact), 1);
      drain();

      @(posedge Clk); #1;
      in_valid = 1'b1;
      {in_red, in_green, in_blue} = 12'h6DF;
      @(posedge Clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge Clk);
      #2 Reset_n = 1'b0;
      @(posedge Clk);
      #2 Reset_n = 1'b1;
      @(negedge Clk);
      chk("rel_out_valid", int'(out_valid), 0);
      chk("rel_in_ready", int'(in_ready), 1);
      send(12'h000, lat);
      chk("rel000_index", int'(out_index), 0);
      chk("rel000_exact", int'(out_exact), 1);
      chk("rel000_latency", lat, LAT_000);
      drain();
      send(12'h6DF, lat);
      chk("rel6DF_index", int'(out_index), 0);
      chk("rel6DF_exact", int'(out_exact), 0);
      drain();

      for (int it = 0; it < 300; it++) begin
         op = int'($urandom_range(0, 7));
         if (op < 3) begin
            wr(4'($urandom_range(0, 15)), 12'($urandom));
         end else begin
            if ($urandom_range(0, 1) == 1) p = 12'($urandom);
            else begin
               p = m_pal[$urandom_range(0, 15)];
               if ($urandom_range(0, 1) == 1)
                  p = p ^ 12'(1 << $urandom_range(0, 11));
            end
            send(p, lat);
            if (op == 7) begin
               out_ready = 1'b0;
               pal_we = 1'b1;
               pal_waddr = 4'($urandom_range(0, 15));
               pal_wdata = 12'($urandom);
               repeat (3) @(negedge Clk);
               out_ready = 1'b1;
               n = 0;
               while (!pal_wready && n < 50) begin
                  @(negedge Clk);
                  n++;
               end
               if (!pal_wready) timeout("rnd_write");
               @(posedge Clk); #1;
               pal_we = 1'b0;
            end else begin
               n = 0;
               while (out_valid && n < 200) begin
                  out_ready = 1'($urandom_range(0, 1));
                  @(negedge Clk);
                  n++;
               end
               if (out_valid) timeout("rnd_drain");
               out_ready = 1'b1;
            end
         end
      end

      repeat (2) @(negedge Clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
